// File: rtl/tilemap_write_sched.sv
// Tile-map RAM write scheduler: round-robin arbitration of two requesters into a
// write FIFO, a full-map fill engine, and writes gated to non-active video.
module tilemap_write_sched #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 6,
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 30
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vga_active,
  input  logic                          req_a,
  input  logic [ADDR_W-1:0]             addr_a,
  input  logic [DATA_W-1:0]             data_a,
  output logic                          ack_a,
  input  logic                          req_b,
  input  logic [ADDR_W-1:0]             addr_b,
  input  logic [DATA_W-1:0]             data_b,
  output logic                          ack_b,
  input  logic                          fill_start,
  input  logic [DATA_W-1:0]             fill_data,
  output logic                          fill_busy,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned COL_W = 6;
  localparam int unsigned ROW_W = ADDR_W - COL_W;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                     state, state_n;
  logic [ADDR_W+DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic                       last_b;
  logic                       push, pop;
  logic [ADDR_W+DATA_W-1:0]   push_word;
  logic [ROW_W-1:0]           row, row_n;
  logic [COL_W-1:0]           col, col_n;
  logic [DATA_W-1:0]          fill_val, fill_val_n;
  logic                       wr_en_n;
  logic [ADDR_W-1:0]          wr_addr_n;
  logic [DATA_W-1:0]          wr_data_n;

  // last_b resets high so A wins the first tie; grants use the registered count only
  always_comb begin
    ack_a = 1'b0;
    ack_b = 1'b0;
    if (fifo_count != FULL_CNT) begin
      if (req_a && (!req_b || last_b)) ack_a = 1'b1;
      else if (req_b)                  ack_b = 1'b1;
    end
  end

  assign push      = ack_a | ack_b;
  assign push_word = ack_a ? {addr_a, data_a} : {addr_b, data_b};
  assign fill_busy = (state == FILL);

  always_comb begin
    state_n    = state;
    row_n      = row;
    col_n      = col;
    fill_val_n = fill_val;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (fill_start) begin
          state_n    = FILL;
          row_n      = '0;
          col_n      = '0;
          fill_val_n = fill_data;
        end else if (!vga_active && fifo_count != '0) begin
          pop                    = 1'b1;
          wr_en_n                = 1'b1;
          {wr_addr_n, wr_data_n} = mem[rd_ptr];
        end
      end
      FILL: begin
        if (!vga_active) begin
          wr_en_n   = 1'b1;
          wr_addr_n = {row, col};
          wr_data_n = fill_val;
          if (col == COL_LAST) begin
            col_n = '0;
            if (row == ROW_LAST) begin
              row_n   = '0;
              state_n = IDLE;
            end else begin
              row_n = row + 1'b1;
            end
          end else begin
            col_n = col + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      fill_val   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_b     <= 1'b1;
    end else begin
      state    <= state_n;
      row      <= row_n;
      col      <= col_n;
      fill_val <= fill_val_n;
      wr_en    <= wr_en_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        last_b <= ack_b;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
